fetch_decode_seq: RTL and testbench

//   Instruction sequencer directly upstream of the ALU. Fetches 16-bit words from program

---
 rtl/fetch_decode_seq.sv | 205 ++++++++++++++++++++
 tb/tb_fetch_decode_seq.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_seq.sv
// fetch_decode_seq: instruction sequencer sitting directly in front of the ALU.
// It fetches 16-bit words, decodes the opcode byte and owns the A/B accumulators
// and the PC. It hands operands to the ALU with a one-cycle run strobe, then
// writes the ALU results back.
// Optional feature macro: FETCH_IRQ_EN. When defined, an interrupt is taken on
// entry to FETCH. When undefined, irq is ignored and irq_ack stays low.
module fetch_decode_seq #(
    parameter int              PC_W       = 12,
    parameter int              DATA_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC   = 12'h000,
    parameter logic [PC_W-1:0] IRQ_VECTOR = 12'h002
) (
    input  logic              pixel_clock,
    input  logic              reset,
    output logic [PC_W-1:0]   mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [7:0]        operation,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [PC_W-1:0]   pc,
    output logic              run,
    input  logic [DATA_W-1:0] alu_a1,
    input  logic [DATA_W-1:0] alu_b1,
    input  logic [PC_W-1:0]   alu_pcnew,
    input  logic              alu_ion,
    input  logic              irq,
    output logic              irq_ack,
    output logic              halted,
    output logic              illegal
);

    // S_IRQ is reachable only when the interrupt feature is built in.
    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT,
        S_IRQ
    } state_t;

    state_t            state;
    state_t            next_state;
    state_t            fetch_target;
    logic [PC_W-1:0]   pc_reg;
    logic [DATA_W-1:0] acc_a;
    logic [DATA_W-1:0] acc_b;
    logic [DATA_W-1:0] ir;
    logic              rd_q;
    logic              illegal_q;
    logic [7:0]        dec_op;
    logic              dec_alu;
    logic              dec_nop;
    logic              dec_hlt;
    logic              fetch_done;
    logic [PC_W-1:0]   pc_plus1;
    logic              unused_ir_low;

    assign dec_op     = ir[15:8];
    assign dec_alu    = (dec_op >= 8'h71) && (dec_op <= 8'h7D);
    assign dec_nop    = (dec_op == 8'h00);
    assign dec_hlt    = (dec_op == 8'h7F);
    assign fetch_done = (state == S_FETCH) && rd_q && mem_ready;
    assign pc_plus1   = pc_reg + 1'b1;
    assign mem_addr   = pc_reg;
    assign mem_rd     = rd_q;
    assign illegal    = illegal_q;
    assign unused_ir_low = ^ir[7:0];

`ifdef FETCH_IRQ_EN
    // Entering FETCH diverts through S_IRQ when an enabled interrupt is pending.
    always_comb begin
        fetch_target = S_FETCH;
        if (irq && alu_ion) begin
            fetch_target = S_IRQ;
        end
    end
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{irq, alu_ion, IRQ_VECTOR};

    // Without the interrupt feature every return goes straight to FETCH.
    always_comb begin
        fetch_target = S_FETCH;
    end
`endif

    // State register; reset lands in FETCH.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the per-state strobes.
    always_comb begin
        next_state = state;
        run        = 1'b0;
        irq_ack    = 1'b0;
        halted     = 1'b0;
        case (state)
            S_FETCH: begin
                if (fetch_done) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_alu) begin
                    next_state = S_EXEC;
                end else if (dec_hlt) begin
                    next_state = S_HALT;
                end else begin
                    next_state = fetch_target;
                end
            end
            S_EXEC: begin
                run        = 1'b1;
                next_state = S_WB;
            end
            S_WB: begin
                next_state = fetch_target;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_IRQ: begin
                irq_ack    = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

    // The read request is registered so that reset clears it at once. It is
    // raised whenever the sequencer is about to sit in FETCH.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= (next_state == S_FETCH);
        end
    end

    // Datapath: instruction capture, operand hand-off, write-back and interrupt entry.
    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            pc_reg    <= RESET_PC;
            acc_a     <= '0;
            acc_b     <= '0;
            ir        <= '0;
            operation <= 8'h00;
            a         <= '0;
            b         <= '0;
            pc        <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (fetch_done) begin
                        ir     <= mem_rdata;
                        pc_reg <= pc_plus1;
                    end
                end
                S_DECODE: begin
                    if (dec_alu) begin
                        operation <= dec_op;
                        a         <= acc_a;
                        b         <= acc_b;
                        pc        <= pc_reg;
                    end else if (!dec_nop && !dec_hlt) begin
                        illegal_q <= 1'b1;
                    end
                end
                S_WB: begin
                    case (operation)
                        8'h71, 8'h72: acc_a <= alu_a1;
                        8'h73:        acc_a <= '0;
                        8'h74:        acc_b <= '0;
                        8'h75, 8'h76, 8'h77: acc_b <= alu_b1;
                        8'h7C, 8'h7D: begin
                            if (alu_pcnew == pc_plus1) begin
                                pc_reg <= alu_pcnew;
                            end
                        end
                        default: ;
                    endcase
                end
`ifdef FETCH_IRQ_EN
                S_IRQ: begin
                    pc_reg <= IRQ_VECTOR;
                    acc_b  <= {{(DATA_W-PC_W){1'b0}}, pc_reg};
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_seq.sv
// tb_fetch_decode_seq: scoreboard bench for fetch_decode_seq.
// An instruction-level interpreter predicts every fetch and every ALU hand-off.
// A memory model with random wait states and an ALU model drive the DUT.
// A monitor pops the predictions and compares them with what the DUT presents.
module tb_fetch_decode_seq;

    logic        pixel_clock = 1'b0;
    logic        reset       = 1'b1;
    logic [11:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [7:0]  operation;
    logic [15:0] a;
    logic [15:0] b;
    logic [11:0] pc;
    logic        run;
    logic [15:0] alu_a1;
    logic [15:0] alu_b1;
    logic [11:0] alu_pcnew;
    logic        alu_ion;
    logic        irq;
    logic        irq_ack;
    logic        halted;
    logic        illegal;

    typedef struct {
        logic [11:0] addr;
        logic        ill;
        int          gap;
    } fetch_t;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [11:0] rpc;
    } run_t;

    fetch_t      fq[$];
    run_t        rq[$];
    logic [15:0] mem [0:4095];
    logic [15:0] mm  [0:4095];

    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    int  irq_cnt = 0;
    int  wait_left = 0;
    bit  mem_en = 0;
    bit  mon_en = 0;
    bit  patch_en = 0;
    bit  irq_rand = 0;
    bit  ion_rand = 0;
    logic model_ill;

    fetch_decode_seq dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .operation   (operation),
        .a           (a),
        .b           (b),
        .pc          (pc),
        .run         (run),
        .alu_a1      (alu_a1),
        .alu_b1      (alu_b1),
        .alu_pcnew   (alu_pcnew),
        .alu_ion     (alu_ion),
        .irq         (irq),
        .irq_ack     (irq_ack),
        .halted      (halted),
        .illegal     (illegal)
    );

    // Free-running clock.
    always #5 pixel_clock = ~pixel_clock;

    // Cycle counter used for latency checks.
    always @(posedge pixel_clock) cyc <= cyc + 1;

    // Counts interrupt-taken pulses.
    always @(negedge pixel_clock) if (irq_ack) irq_cnt <= irq_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Whether the external ALU reports a skip for SC/SZ.
    function automatic bit skipTaken(input logic [15:0] xa, input logic [15:0] xb, input logic [11:0] xpc);
        return xa[0] ^ xb[1] ^ xpc[0];
    endfunction

    // Memory model: serves reads after 0-3 random wait cycles. After serving
    // 12'hFFF it optionally plants a HLT at 12'h000 so the run ends after the wrap.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(posedge pixel_clock);
            #1;
            if (!mem_en) begin
                mem_ready = 1'b0;
                wait_left = 0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_rd && !reset) begin
                if (wait_left == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (patch_en && mem_addr == 12'hFFF) mem[0] = 16'h7F00;
                    wait_left = $urandom_range(0, 3);
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // ALU model: computes results during EXEC. Operations that produce no
    // result get junk on a1/b1 and pc+1 on pcnew, so a wrong capture is visible.
    initial begin
        alu_a1 = 16'h0; alu_b1 = 16'h0; alu_pcnew = 12'h0; alu_ion = 1'b0; irq = 1'b0;
        forever begin
            @(negedge pixel_clock);
            if (ion_rand) alu_ion = 1'($urandom_range(0, 1));
            if (irq_rand) irq = 1'($urandom_range(0, 1));
            if (run) begin
                alu_a1    = 16'($urandom);
                alu_b1    = 16'($urandom);
                alu_pcnew = pc + 12'd1;
                case (operation)
                    8'h71: alu_a1 = a + b;
                    8'h72: alu_a1 = a & b;
                    8'h75: alu_b1 = ~b;
                    8'h76: alu_b1 = b + 16'd1;
                    8'h77: alu_b1 = b - 16'd1;
                    8'h7C, 8'h7D: alu_pcnew = skipTaken(a, b, pc) ? pc + 12'd1 : pc + 12'd5;
                    default: ;
                endcase
            end
        end
    end

    // Monitor: pops predictions on every fetch handshake and every run strobe.
    initial begin : monitor
        bit     prev_rd;
        int     first_rd;
        int     last_hs;
        fetch_t fe;
        run_t   re;
        prev_rd = 0; first_rd = 0; last_hs = 0;
        forever begin
            @(negedge pixel_clock);
            if (mon_en) begin
                if (mem_rd && !prev_rd) first_rd = cyc;
                prev_rd = mem_rd;
                if (mem_rd && mem_ready) begin
                    checkOutput("fetch_expected", 32'(fq.size() != 0), 32'd1);
                    if (fq.size() != 0) begin
                        fe = fq.pop_front();
                        checkOutput("fetch_addr", 32'(mem_addr), 32'(fe.addr));
                        checkOutput("illegal_flag", 32'(illegal), 32'(fe.ill));
                        if (fe.gap != 0) checkOutput("fetch_latency", first_rd - last_hs, fe.gap);
                    end
                    last_hs = cyc;
                end
                if (run) begin
                    checkOutput("run_expected", 32'(rq.size() != 0), 32'd1);
                    if (rq.size() != 0) begin
                        re = rq.pop_front();
                        checkOutput("run_op", 32'(operation), 32'(re.op));
                        checkOutput("run_a", 32'(a), 32'(re.ra));
                        checkOutput("run_b", 32'(b), 32'(re.rb));
                        checkOutput("run_pc", 32'(pc), 32'(re.rpc));
                        checkOutput("run_latency", cyc - last_hs, 2);
                    end
                end
            end
        end
    end

    // Loads the program image: a directed prologue that builds A=5, B=3 and adds
    // them, an illegal word, then a random block and NOPs up to the top of memory.
    task automatic applyStimulus();
        logic [15:0] prologue [0:13];
        int r;
        logic [7:0] op;
        prologue = '{16'h7600, 16'h7600, 16'h7600, 16'h7600, 16'h7600, 16'h7100,
                     16'h7400, 16'h7600, 16'h7600, 16'h7600, 16'h7100, 16'h0000,
                     16'h5A00, 16'h7800};
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 14; i++) mem[i] = prologue[i];
        for (int i = 14; i < 256; i++) begin
            r = $urandom_range(0, 15);
            if (r <= 12) op = 8'h71 + 8'(r);
            else if (r == 14) begin
                case ($urandom_range(0, 3))
                    0: op = 8'h5A;
                    1: op = 8'h70;
                    2: op = 8'h7E;
                    default: op = 8'($urandom_range(8'h80, 8'hFF));
                endcase
            end else op = 8'h00;
            mem[i] = {op, 8'($urandom)};
        end
    endtask

    // Instruction-level reference: walks the program from the reset PC and
    // records each fetch address and each ALU hand-off it implies.
    task automatic buildModel();
        logic [11:0] p;
        logic [15:0] ra, rb;
        logic        ill;
        logic [7:0]  op;
        int          gap;
        bit          done;
        for (int i = 0; i < 4096; i++) mm[i] = mem[i];
        p = 12'h000; ra = 16'h0; rb = 16'h0; ill = 1'b0; gap = 0; done = 0;
        for (int n = 0; n < 6000 && !done; n++) begin
            fq.push_back('{p, ill, gap});
            op = mm[p][15:8];
            if (p == 12'hFFF) mm[0] = 16'h7F00;
            p = p + 12'd1;
            if (op >= 8'h71 && op <= 8'h7D) begin
                rq.push_back('{op, ra, rb, p});
                case (op)
                    8'h71: ra = ra + rb;
                    8'h72: ra = ra & rb;
                    8'h73: ra = 16'h0;
                    8'h74: rb = 16'h0;
                    8'h75: rb = ~rb;
                    8'h76: rb = rb + 16'd1;
                    8'h77: rb = rb - 16'd1;
                    8'h7C, 8'h7D: if (skipTaken(ra, rb, p)) p = p + 12'd1;
                    default: ;
                endcase
                gap = 4;
            end else if (op == 8'h7F) begin
                done = 1;
            end else begin
                if (op != 8'h00) ill = 1'b1;
                gap = 2;
            end
        end
        model_ill = ill;
    endtask

    task automatic runResetTest();
        mem_en = 0; mon_en = 0; reset = 1'b1;
        repeat (2) @(posedge pixel_clock);
        #1;
        checkOutput("reset_mem_rd", 32'(mem_rd), 32'd0);
        checkOutput("reset_run", 32'(run), 32'd0);
        checkOutput("reset_halted", 32'(halted), 32'd0);
        checkOutput("reset_illegal", 32'(illegal), 32'd0);
        checkOutput("reset_irq_ack", 32'(irq_ack), 32'd0);
        checkOutput("reset_operation", 32'(operation), 32'd0);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'h000);
        checkOutput("reset_a", 32'(a), 32'd0);
        checkOutput("reset_b", 32'(b), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge pixel_clock);
        checkOutput("fetch_request", 32'(mem_rd), 32'd1);
        repeat (3) @(negedge pixel_clock);
        checkOutput("fetch_stall_hold", 32'(mem_rd), 32'd1);
        #2 reset = 1'b1;
        #1 checkOutput("reset_mid_fetch_rd", 32'(mem_rd), 32'd0);
        @(posedge pixel_clock);
        #1 reset = 1'b0;
        repeat (2) @(negedge pixel_clock);
        checkOutput("addr_after_release", 32'(mem_addr), 32'h000);
        checkOutput("rd_after_release", 32'(mem_rd), 32'd1);
    endtask

    task automatic runProgramTest();
        reset = 1'b1; mem_en = 0; mon_en = 0;
        @(posedge pixel_clock);
        #2;
        applyStimulus();
        fq.delete(); rq.delete();
        buildModel();
        patch_en = 1; ion_rand = 1;
`ifndef FETCH_IRQ_EN
        irq_rand = 1;
`endif
        irq_cnt = 0;
        mem_en = 1; mon_en = 1;
        @(posedge pixel_clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 40000 && !halted; i++) @(negedge pixel_clock);
        checkOutput("halt_reached", 32'(halted), 32'd1);
        checkOutput("fetches_left", fq.size(), 0);
        checkOutput("runs_left", rq.size(), 0);
        checkOutput("illegal_final", 32'(illegal), 32'(model_ill));
        repeat (5) @(negedge pixel_clock);
        checkOutput("halt_no_fetch", 32'(mem_rd), 32'd0);
        checkOutput("halt_no_run", 32'(run), 32'd0);
        checkOutput("halt_held", 32'(halted), 32'd1);
        checkOutput("irq_ack_idle", irq_cnt, 0);
        mon_en = 0; patch_en = 0; irq_rand = 0; ion_rand = 0;
        irq = 1'b0;
    endtask

    // ADD at 12'h020 with an interrupt raised during its EXEC cycle.
    task automatic runIrqTest();
        bit          found;
        logic [11:0] next_addr;
        reset = 1'b1; mem_en = 0; alu_ion = 1'b1; irq = 1'b0;
        @(posedge pixel_clock);
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h002] = 16'h7200;
        mem[12'h020] = 16'h7100;
        mem_en = 1;
        #1 reset = 1'b0;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge pixel_clock);
            if (run && pc == 12'h021) found = 1;
        end
        checkOutput("irq_add_reached", 32'(found), 32'd1);
        irq = 1'b1;
        irq_cnt = 0;
        found = 0; next_addr = 12'h000;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge pixel_clock);
            if (mem_rd && mem_ready) begin found = 1; next_addr = mem_addr; end
        end
        irq = 1'b0;
        checkOutput("irq_fetch_seen", 32'(found), 32'd1);
`ifdef FETCH_IRQ_EN
        checkOutput("irq_next_addr", 32'(next_addr), 32'h002);
        checkOutput("irq_ack_pulses", irq_cnt, 1);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge pixel_clock);
            if (run) found = 1;
        end
        checkOutput("irq_vector_run", 32'(found), 32'd1);
        checkOutput("irq_return_b", 32'(b), 32'h0021);
`else
        checkOutput("irq_next_addr", 32'(next_addr), 32'h021);
        checkOutput("irq_ack_pulses", irq_cnt, 0);
`endif
        reset = 1'b1;
        mem_en = 0;
    endtask

    // Test sequence and summary.
    initial begin
        runResetTest();
        runProgramTest();
        runIrqTest();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
